// File: rtl/fe_iq_pkg.sv
// fe_iq_pkg: packet types shared by fetch, the instruction queue and decode
package fe_iq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] simid;
    } t_instr_pkt;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } t_br_mispred_pkt;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } t_nuke_pkt;

endpackage

// File: rtl/fe_iq.sv
// fe_iq: in-order instruction queue between fetch and decode, flushed on mispredict or nuke
module fe_iq
    import fe_iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  t_br_mispred_pkt br_mispred_ex0,
    input  t_nuke_pkt       nuke_rb1,
    input  logic            valid_fe1,
    input  t_instr_pkt      instr_fe1,
    output logic            iq_ready_fe1,
    output logic            valid_iq0,
    output t_instr_pkt      instr_iq0,
    input  logic            decode_ready_de0,
    output logic            iq_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    t_instr_pkt    entry_q [DEPTH];
    t_instr_pkt    entry_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush, enq, deq;

    logic unused_ok;
    assign unused_ok = ^{br_mispred_ex0.target, nuke_rb1.pc};

    // Handshakes: ready comes only from the registered count, head is read straight from the array
    always_comb begin
        flush        = br_mispred_ex0.valid | nuke_rb1.valid;
        iq_ready_fe1 = count_q != FULL;
        valid_iq0    = (count_q != '0) & ~flush;
        iq_empty     = count_q == '0;
        instr_iq0    = entry_q[rd_ptr_q];
        enq          = valid_fe1 & iq_ready_fe1 & ~flush;
        deq          = valid_iq0 & decode_ready_de0;
    end

    // Next state: write at tail, advance pointers, flush wins over everything
    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q + PW'(deq);
        wr_ptr_d = wr_ptr_q + PW'(enq);
        count_d  = count_q + CW'(enq) - CW'(deq);
        if (enq) entry_d[wr_ptr_q] = instr_fe1;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State register; entry contents need no reset since count gates their visibility
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifndef SYNTHESIS
    logic [15:0] last_simid_q;
    logic        seen_q;

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= FULL);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) deq |-> count_q != '0);
    a_no_enq_full: assert property (@(posedge clk) disable iff (reset) enq |-> count_q != FULL);
    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (valid_iq0 & ~decode_ready_de0 & ~flush) |=> $stable(instr_iq0));

    // Dequeued SIMIDs must keep increasing in program order
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= 1'b0;
        end else if (deq) begin
            a_simid_order: assert (!seen_q || instr_iq0.simid > last_simid_q);
            seen_q       <= 1'b1;
            last_simid_q <= instr_iq0.simid;
        end
    end
`endif

endmodule

// File: tb/tb_fe_iq.sv
// tb_fe_iq: directed and randomised scoreboard bench for the fetch/decode instruction queue
module tb_fe_iq;
    import fe_iq_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    t_br_mispred_pkt br_mispred_ex0;
    t_nuke_pkt       nuke_rb1;
    logic            valid_fe1;
    t_instr_pkt      instr_fe1;
    logic            iq_ready_fe1;
    logic            valid_iq0;
    t_instr_pkt      instr_iq0;
    logic            decode_ready_de0;
    logic            iq_empty;

    t_instr_pkt sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         next_id = 1;
    int         t2_end;
    bit         fl;

    always #5 clk = ~clk;

    fe_iq #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_mispred_ex0   (br_mispred_ex0),
        .nuke_rb1         (nuke_rb1),
        .valid_fe1        (valid_fe1),
        .instr_fe1        (instr_fe1),
        .iq_ready_fe1     (iq_ready_fe1),
        .valid_iq0        (valid_iq0),
        .instr_iq0        (instr_iq0),
        .decode_ready_de0 (decode_ready_de0),
        .iq_empty         (iq_empty)
    );

    function automatic t_instr_pkt mk(input int id);
        t_instr_pkt p;
        p.pc    = 32'h1000 + 32'(id) * 32'd4;
        p.instr = 32'(id) * 32'h9E3779B1;
        p.simid = 16'(id);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One cycle of stimulus, entered and left at posedge+1; accepted packets go to the scoreboard
    task automatic step(input bit v, input bit dr, input bit bm, input bit nk, input bit r);
        bit acc;
        reset                 = r;
        valid_fe1             = v;
        instr_fe1             = mk(next_id);
        decode_ready_de0      = dr;
        br_mispred_ex0.valid  = bm;
        nuke_rb1.valid        = nk;
        acc = v && !r && !bm && !nk && sb.size() != DEPTH;
        @(negedge clk);
        #1;
        if (acc) begin
            sb.push_back(mk(next_id));
            next_id++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare status outputs against the scoreboard and pop on every dequeue
    always @(negedge clk) begin
        fl = br_mispred_ex0.valid | nuke_rb1.valid;
        if (reset) begin
            sb.delete();
        end else begin
            chk("valid_iq0", 80'(valid_iq0), 80'(sb.size() != 0 && !fl));
            chk("iq_ready_fe1", 80'(iq_ready_fe1), 80'(sb.size() != DEPTH));
            chk("iq_empty", 80'(iq_empty), 80'(sb.size() == 0));
            if (valid_iq0 && decode_ready_de0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL deq_empty: dequeue with nothing expected, got simid %0d", instr_iq0.simid);
                end else begin
                    chk("head", instr_iq0, sb.pop_front());
                end
            end
            if (fl) sb.delete();
        end
    end

    initial begin
        valid_fe1        = 1'b0;
        instr_fe1        = '0;
        decode_ready_de0 = 1'b0;
        br_mispred_ex0   = '0;
        nuke_rb1         = '0;
        repeat (3) @(posedge clk);
        #1;
        // pass-through with decode always ready
        repeat (3) step(1, 1, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        // backpressure: five packets offered, four fit, fifth held until space
        t2_end = next_id + 5;
        repeat (6) step(next_id < t2_end, 0, 0, 0, 0);
        repeat (8) step(next_id < t2_end, 1, 0, 0, 0);
        // full queue with continuous traffic both sides
        repeat (4) step(1, 0, 0, 0, 0);
        repeat (8) step(1, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 0);
        // mispredict with a packet arriving: it is dropped, the next one becomes head
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        // nuke while full and decode ready
        repeat (4) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        // reset and flush together
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        // random traffic with occasional flushes
        repeat (3000) step($urandom_range(3) != 0, $urandom_range(2) != 0,
                           $urandom_range(39) == 0, $urandom_range(49) == 0, 0);
        repeat (DEPTH + 2) step(0, 1, 0, 0, 0);
        chk("drained", 80'(sb.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
